// File: rtl/mem_pkg.sv
// Shared defaults and port-index type for the multi-port memory (mem_mp) and its arbiter.
package mem_pkg;
    localparam int MEM_WIDTH_DEF  = 16;
    localparam int MEM_DEPTH_DEF  = 64;
    localparam int MEM_NPORTS_DEF = 2;
    localparam int MEM_PORT_MAX   = 8;

    typedef logic [2:0] port_idx_t;

    // Round-robin successor of port g among nports channels.
    function automatic port_idx_t next_port(input port_idx_t g, input int nports);
        if (int'(g) + 1 >= nports) return '0;
        return port_idx_t'(int'(g) + 1);
    endfunction
endpackage

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr;
// ptr moves past the granted port only when the grant is consumed (advance).
module mem_rr_arb
    import mem_pkg::*;
#(
    parameter int NPORTS = MEM_NPORTS_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [NPORTS-1:0] req,
    input  logic              advance,
    output logic [NPORTS-1:0] grant,
    output port_idx_t         ptr
);

    port_idx_t gidx;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NPORTS]) begin
                grant = '0;
                grant[(int'(ptr) + i) % NPORTS] = 1'b1;
                gidx = port_idx_t'((int'(ptr) + i) % NPORTS);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= next_port(gidx, NPORTS);
        end
    end

endmodule

// File: rtl/mem_mp.sv
// Multi-port single-clock memory with round-robin access and 1-cycle read latency.
// Optional byte strobes enabled by defining MEM_BYTE_STROBE_EN.
module mem_mp
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH_DEF,
    parameter int DEPTH      = MEM_DEPTH_DEF,
    parameter int NPORTS     = MEM_NPORTS_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [NPORTS-1:0]                valid_i,
    output logic [NPORTS-1:0]                ready_o,
    input  logic [NPORTS-1:0]                wr_rd_i,
    input  logic [NPORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NPORTS-1:0][WIDTH-1:0]     wdata_i,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [NPORTS-1:0][WIDTH/8-1:0]   strb_i,
`endif
    output logic [WIDTH-1:0]                 rdata_o,
    output logic [NPORTS-1:0]                rvalid_o
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [NPORTS-1:0]     grant;
    port_idx_t             ptr;
    logic                  xfer;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [NBYTES-1:0]     sel_strb;
    logic                  in_range;
    logic [IDX_W-1:0]      widx;

    logic [NPORTS-1:0] vld_p1;
    logic [WIDTH-1:0]  rdata_p1;

    mem_rr_arb #(.NPORTS(NPORTS)) u_arb (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .req    (valid_i),
        .advance(xfer),
        .grant  (grant),
        .ptr    (ptr)
    );

    assign ready_o = reset_i ? '0 : (grant & valid_i);
    assign xfer    = |ready_o;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (grant[p]) begin
                sel_wr    = wr_rd_i[p];
                sel_addr  = addr_i[p];
                sel_wdata = wdata_i[p];
`ifdef MEM_BYTE_STROBE_EN
                sel_strb  = strb_i[p];
`else
                sel_strb  = '1;
`endif
            end
        end
    end

    assign in_range = ({1'b0, sel_addr} < DEPTH_L);
    assign widx     = sel_addr[IDX_W-1:0];

    // Storage: no reset, out-of-range writes are discarded.
    always_ff @(posedge clk_i) begin
        if (xfer && sel_wr && in_range) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (sel_strb[b]) begin
                    mem[widx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage p1: read response, data only refreshed by a read transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1   <= '0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= ready_o & ~wr_rd_i;
            if (xfer && !sel_wr) begin
                rdata_p1 <= in_range ? mem[widx] : '0;
            end
        end
    end

    // A response landing in the first reset cycle must stay invisible.
    assign rvalid_o = reset_i ? '0 : vld_p1;
    assign rdata_o  = reset_i ? '0 : rdata_p1;

endmodule

// File: tb/tb_mem_mp.sv
// Scoreboard bench for mem_mp (2 ports, 16-bit, DEPTH=64 with 7-bit addresses).
module tb_mem_mp;
    localparam int W  = 16;
    localparam int D  = 64;
    localparam int NP = 2;
    localparam int AW = 7;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic [NP-1:0]         valid;
    logic [NP-1:0]         ready;
    logic [NP-1:0]         wr_rd;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][W-1:0]  wdata;
    logic [NP-1:0][1:0]    strb;
    logic [W-1:0]          rdata;
    logic [NP-1:0]         rvalid;

    always #5 clk = ~clk;

    mem_mp #(.WIDTH(W), .DEPTH(D), .NPORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid),
        .ready_o (ready),
        .wr_rd_i (wr_rd),
        .addr_i  (addr),
        .wdata_i (wdata),
`ifdef MEM_BYTE_STROBE_EN
        .strb_i  (strb),
`endif
        .rdata_o (rdata),
        .rvalid_o(rvalid)
    );

    typedef struct {
        logic [NP-1:0] oh;
        logic [W-1:0]  data;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [D];
    int           mptr;
    logic [W-1:0] last_rdata;
    int           nchk  = 0;
    int           npass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: expected grant from the modelled pointer, memory updates, response queue.
    always @(negedge clk) begin
        logic [NP-1:0] exp_rdy;
        int            g;
        logic [1:0]    s;
        exp_t          e;
        if (reset_i) begin
            chk("reset_ready", ready, 0);
            chk("reset_rvalid", rvalid, 0);
            chk("reset_rdata", rdata, 0);
            sb.delete();
            mptr       = 0;
            last_rdata = '0;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rvalid", rvalid, e.oh);
                chk("rdata", rdata, e.data);
                last_rdata = e.data;
            end else begin
                chk("rvalid_idle", rvalid, 0);
                chk("rdata_hold", rdata, last_rdata);
            end
            exp_rdy = '0;
            g = -1;
            for (int i = NP - 1; i >= 0; i--) begin
                if (valid[(mptr + i) % NP]) g = (mptr + i) % NP;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("ready", ready, exp_rdy);
            if (g >= 0) begin
`ifdef MEM_BYTE_STROBE_EN
                s = strb[g];
`else
                s = 2'b11;
`endif
                if (wr_rd[g]) begin
                    if (int'(addr[g]) < D) begin
                        if (s[0]) model[addr[g]][7:0]  = wdata[g][7:0];
                        if (s[1]) model[addr[g]][15:8] = wdata[g][15:8];
                    end
                end else begin
                    e.oh = '0;
                    e.oh[g] = 1'b1;
                    e.data = (int'(addr[g]) < D) ? model[addr[g]] : '0;
                    sb.push_back(e);
                end
                mptr = (g + 1) % NP;
            end
        end
    end

    // Issue one request on port p and hold it until the handshake completes.
    task automatic req(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [1:0] s);
        bit got;
        got = 1'b0;
        valid[p] = 1'b1;
        wr_rd[p] = wr;
        addr[p]  = a;
        wdata[p] = d;
        strb[p]  = s;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = ready[p];
            @(posedge clk);
            #1;
        end
        valid[p] = 1'b0;
        if (!got) chk("handshake_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        valid = '0; wr_rd = '0; addr = '0; wdata = '0; strb = '0;
        repeat (2) @(posedge clk);
        #1 valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 valid[0] = 1'b0;
        reset_i = 1'b0;
        @(posedge clk); #1;

        // Write on port 0 then read back on port 1.
        req(0, 1'b1, 7'd5, 16'hABCD, 2'b11);
        req(1, 1'b0, 7'd5, 16'h0000, 2'b11);
        @(posedge clk); #1;

        // Top address, read immediately after write; out-of-range write/read.
        req(0, 1'b1, 7'd63, 16'h1234, 2'b11);
        req(0, 1'b0, 7'd63, 16'h0000, 2'b11);
        req(0, 1'b1, 7'd6, 16'h5555, 2'b11);
        req(0, 1'b1, 7'd70, 16'h9999, 2'b11);
        req(0, 1'b0, 7'd6, 16'h0000, 2'b11);
        req(1, 1'b0, 7'd70, 16'h0000, 2'b11);
        @(posedge clk); #1;

        // Both ports busy every cycle: grants must alternate.
        for (int i = 10; i < 18; i++) req(0, 1'b1, AW'(i), W'(16'h1000 + i), 2'b11);
        fork
            for (int i = 0; i < 4; i++) req(0, 1'b0, AW'(10 + 2 * i), 16'h0, 2'b11);
            for (int i = 0; i < 4; i++) req(1, 1'b0, AW'(11 + 2 * i), 16'h0, 2'b11);
        join
        @(posedge clk); #1;

        // Port 0 alone for 10 back-to-back reads.
        for (int i = 0; i < 10; i++) req(0, 1'b0, 7'd5, 16'h0, 2'b11);

`ifdef MEM_BYTE_STROBE_EN
        req(0, 1'b1, 7'd20, 16'hFFFF, 2'b11);
        req(0, 1'b1, 7'd20, 16'h1200, 2'b10);
        req(0, 1'b0, 7'd20, 16'h0000, 2'b11);
        req(1, 1'b1, 7'd20, 16'hAAAA, 2'b00);
        req(1, 1'b0, 7'd20, 16'h0000, 2'b11);
`endif

        // Reset right after a read is accepted: its response is suppressed.
        req(1, 1'b0, 7'd5, 16'h0, 2'b11);
        reset_i = 1'b1;
        valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        valid[1] = 1'b0;
        req(0, 1'b0, 7'd5, 16'h0, 2'b11);

        // Random mixed traffic on both ports over initialised and out-of-range addresses.
        for (int i = 0; i < 20; i++) req(0, 1'b1, AW'(i), W'($urandom), 2'b11);
        fork
            for (int i = 0; i < 25; i++)
                req(0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? AW'($urandom_range(64, 127)) : AW'($urandom_range(0, 19)),
                    W'($urandom), 2'($urandom_range(0, 3)));
            for (int i = 0; i < 25; i++)
                req(1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? AW'($urandom_range(64, 127)) : AW'($urandom_range(0, 19)),
                    W'($urandom), 2'($urandom_range(0, 3)));
        join
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
